bit_serializer: RTL and testbench

- Parallel-to-serial converter that sits directly upstream of the serial sequence-detector FSM.
- Accepts a WIDTH-bit word through a load/ready handshake and shifts it out one bit per clock on ser_out; the detector samples that stream as its single-bit input.
- Flags the last bit of each word and counts completed words, so the detector's match pulses can be correlated with frame position.

---
 rtl/bit_serializer.sv | 112 +++++++++++
 tb/tb_bit_serializer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter feeding the sequence detector: one WIDTH-bit word
// per load/ready handshake, shifted out one bit per clock with a last-bit flag.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             last,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int BCW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [BCW-1:0]   r_bit_cnt;
    logic             r_ser_out;
    logic             r_ser_valid;
    logic             r_last;
    logic             r_ready;
    logic [CNT_W-1:0] r_frame_cnt;
    logic             w_accept;

    // Bit that leaves the word first, according to the configured order.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its head bit consumed, so the next bit moves into head position.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign w_accept = load && r_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_ser_out   <= IDLE_BIT;
            r_ser_valid <= 1'b0;
            r_last      <= 1'b0;
            r_ready     <= 1'b1;
            r_frame_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_ser_out   <= head_bit(data_in);
                        r_shreg     <= advance(data_in);
                        r_bit_cnt   <= BCW'(WIDTH - 1);
                        r_ser_valid <= 1'b1;
                        r_last      <= 1'b0;
                        r_ready     <= 1'b0;
                        r_state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (r_bit_cnt == '0) begin
                        // Last-bit cycle ends: count the frame, then chain or go idle.
                        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                        r_last      <= 1'b0;
                        if (w_accept) begin
                            r_ser_out   <= head_bit(data_in);
                            r_shreg     <= advance(data_in);
                            r_bit_cnt   <= BCW'(WIDTH - 1);
                            r_ser_valid <= 1'b1;
                            r_ready     <= 1'b0;
                        end else begin
                            r_ser_out   <= IDLE_BIT;
                            r_ser_valid <= 1'b0;
                            r_ready     <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end else begin
                        r_ser_out <= head_bit(r_shreg);
                        r_shreg   <= advance(r_shreg);
                        r_bit_cnt <= r_bit_cnt - BCW'(1);
                        // Entering the final bit: flag it and open the handshake early
                        // so a following word can chain without a gap.
                        if (r_bit_cnt == BCW'(1)) begin
                            r_last  <= 1'b1;
                            r_ready <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready     = r_ready;
    assign ser_out   = r_ser_out;
    assign ser_valid = r_ser_valid;
    assign last      = r_last;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first, LSB-first and 2-bit-counter instances,
// with per-bit expectations queued at load time and compared as bits emerge.
module tb_bit_serializer;

    logic       clk;
    logic [2:0] rst_v;
    logic [2:0] load_v;
    logic [7:0] din_a, din_b, din_c;
    logic [2:0] ready_v, sout_v, sval_v, last_v;
    logic [7:0] fc_a, fc_b;
    logic [1:0] fc_c;

    typedef struct packed {
        logic b;
        logic l;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    int   exp_fc[3];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 0;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst_v[0]), .data_in(din_a), .load(load_v[0]),
        .ready(ready_v[0]), .ser_out(sout_v[0]), .ser_valid(sval_v[0]),
        .last(last_v[0]), .frame_cnt(fc_a));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst_v[1]), .data_in(din_b), .load(load_v[1]),
        .ready(ready_v[1]), .ser_out(sout_v[1]), .ser_valid(sval_v[1]),
        .last(last_v[1]), .frame_cnt(fc_b));

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst_v[2]), .data_in(din_c), .load(load_v[2]),
        .ready(ready_v[2]), .ser_out(sout_v[2]), .ser_valid(sval_v[2]),
        .last(last_v[2]), .frame_cnt(fc_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_word(input int idx, input logic [7:0] w);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.b = (idx == 1) ? w[i] : w[7-i];
            e.l = (i == 7);
            if (idx == 0) q_a.push_back(e);
            else if (idx == 1) q_b.push_back(e);
        end
    endfunction

    function automatic logic [31:0] get_fc(input int idx);
        if (idx == 0) return {24'd0, fc_a};
        if (idx == 1) return {24'd0, fc_b};
        return {30'd0, fc_c};
    endfunction

    function automatic logic [31:0] model_fc(input int idx);
        return (idx == 2) ? (exp_fc[idx] % 4) : (exp_fc[idx] % 256);
    endfunction

    task automatic set_din(input int idx, input logic [7:0] w);
        if (idx == 0) din_a = w;
        else if (idx == 1) din_b = w;
        else din_c = w;
    endtask

    // One isolated word: load for one edge, then watch all 8 bit cycles and the idle after.
    task automatic send_word(input int idx, input logic [7:0] w);
        set_din(idx, w);
        load_v[idx] = 1'b1;
        push_word(idx, w);
        tick();
        load_v[idx] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            check_eq("sw_valid", {31'd0, sval_v[idx]}, 32'd1);
            check_eq("sw_ready", {31'd0, ready_v[idx]}, (k == 8) ? 32'd1 : 32'd0);
            check_eq("sw_last", {31'd0, last_v[idx]}, (k == 8) ? 32'd1 : 32'd0);
            tick();
        end
        exp_fc[idx]++;
        check_eq("sw_fc", get_fc(idx), model_fc(idx));
        check_eq("sw_idle_valid", {31'd0, sval_v[idx]}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sval_v[0]) begin
                if (q_a.size() == 0) check_eq("a_extra_bit", 32'd1, 32'd0);
                else begin
                    e_a = q_a.pop_front();
                    check_eq("a_bit", {31'd0, sout_v[0]}, {31'd0, e_a.b});
                    check_eq("a_last", {31'd0, last_v[0]}, {31'd0, e_a.l});
                end
                check_eq("a_ready_inv", {31'd0, ready_v[0]}, {31'd0, last_v[0]});
            end else begin
                check_eq("a_idle_outs", {29'd0, sout_v[0], last_v[0], ready_v[0]}, 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (sval_v[1]) begin
                if (q_b.size() == 0) check_eq("b_extra_bit", 32'd1, 32'd0);
                else begin
                    e_b = q_b.pop_front();
                    check_eq("b_bit", {31'd0, sout_v[1]}, {31'd0, e_b.b});
                    check_eq("b_last", {31'd0, last_v[1]}, {31'd0, e_b.l});
                end
                check_eq("b_ready_inv", {31'd0, ready_v[1]}, {31'd0, last_v[1]});
            end else begin
                check_eq("b_idle_outs", {29'd0, sout_v[1], last_v[1], ready_v[1]}, 32'd1);
            end
        end
    end

    initial begin
        rst_v  = 3'b111;
        load_v = 3'b111;
        din_a  = 8'hFF;
        din_b  = 8'hFF;
        din_c  = 8'hFF;
        for (int i = 0; i < 3; i++) exp_fc[i] = 0;

        // Reset held two edges; load is asserted to show rst wins.
        tick();
        mon_en = 1'b1;
        load_v = 3'b000;
        tick();
        rst_v = 3'b000;
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_ready", {31'd0, ready_v[i]}, 32'd1);
            check_eq("rst_valid", {31'd0, sval_v[i]}, 32'd0);
            check_eq("rst_fc", get_fc(i), 32'd0);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("idle_valid", {31'd0, sval_v[0]}, 32'd0);
            check_eq("idle_fc", get_fc(0), 32'd0);
        end

        // Single word, MSB first.
        send_word(0, 8'b0101_0011);

        // Back-to-back words with load held high.
        din_a = 8'hA5;
        load_v[0] = 1'b1;
        push_word(0, 8'hA5);
        tick();
        din_a = 8'h3C;
        push_word(0, 8'h3C);
        for (int k = 1; k <= 8; k++) begin
            check_eq("b2b_valid1", {31'd0, sval_v[0]}, 32'd1);
            tick();
        end
        load_v[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            check_eq("b2b_valid2", {31'd0, sval_v[0]}, 32'd1);
            tick();
        end
        exp_fc[0] += 2;
        check_eq("b2b_fc", get_fc(0), model_fc(0));
        check_eq("b2b_end_valid", {31'd0, sval_v[0]}, 32'd0);

        // Load pulsed while busy must be dropped.
        din_a = 8'hF0;
        load_v[0] = 1'b1;
        push_word(0, 8'hF0);
        tick();
        load_v[0] = 1'b0;
        tick();
        tick();
        din_a = 8'h0F;
        load_v[0] = 1'b1;
        tick();
        load_v[0] = 1'b0;
        check_eq("busy_ready", {31'd0, ready_v[0]}, 32'd0);
        for (int k = 0; k < 5; k++) tick();
        exp_fc[0]++;
        check_eq("busy_fc", get_fc(0), model_fc(0));
        check_eq("busy_valid", {31'd0, sval_v[0]}, 32'd0);
        tick();
        check_eq("busy_no_second", {31'd0, sval_v[0]}, 32'd0);

        // LSB-first instance.
        send_word(1, 8'b0000_0110);

        // Reset during bit 4 aborts the word and clears the frame count.
        din_a = 8'h5A;
        load_v[0] = 1'b1;
        push_word(0, 8'h5A);
        tick();
        load_v[0] = 1'b0;
        tick();
        tick();
        tick();
        rst_v[0] = 1'b1;
        tick();
        rst_v[0] = 1'b0;
        q_a.delete();
        exp_fc[0] = 0;
        check_eq("midrst_valid", {31'd0, sval_v[0]}, 32'd0);
        check_eq("midrst_last", {31'd0, last_v[0]}, 32'd0);
        check_eq("midrst_fc", get_fc(0), 32'd0);
        tick();
        check_eq("midrst_idle", {31'd0, sval_v[0]}, 32'd0);
        send_word(0, 8'hC3);

        // Two-bit frame counter wraps 1,2,3,0,1.
        for (int n = 0; n < 5; n++) send_word(2, 8'($urandom_range(0, 255)));

        tick();
        check_eq("a_queue_drained", q_a.size(), 32'd0);
        check_eq("b_queue_drained", q_b.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
